// File: rtl/demux_212_buf.sv
// Buffered 1:2 demultiplexer: one producer is steered by sel to two independent
// FIFOs (zero/one), each with its own valid/ready handshake and occupancy count.

module demux_212_buf_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             wr_data,
    input  logic                     push,
    input  logic                     pop_req,
    output logic [W-1:0]             rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == FULL_CNT);

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign wr_en = push & ~full;
    assign rd_en = pop_req & valid;

    // Storage holds data only; emptiness is tracked by the count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Empty FIFOs present zero rather than stale or uninitialised storage.
    assign rd_data = valid ? mem[rd_ptr] : '0;
    assign cnt     = cnt_q;

endmodule

module demux_212_buf #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             in,
    input  logic                     in_valid,
    input  logic                     sel,
    output logic                     in_ready,
    output logic [W-1:0]             zero,
    output logic                     zero_valid,
    input  logic                     zero_ready,
    output logic [$clog2(DEPTH):0]   zero_cnt,
    output logic [W-1:0]             one,
    output logic                     one_valid,
    input  logic                     one_ready,
    output logic [$clog2(DEPTH):0]   one_cnt
);

    logic zero_full;
    logic one_full;
    logic push_zero;
    logic push_one;

    // Readiness depends only on the selected FIFO's registered fullness, never on consumer ready.
    assign in_ready  = sel ? ~one_full : ~zero_full;
    assign push_zero = in_valid & in_ready & ~sel;
    assign push_one  = in_valid & in_ready &  sel;

    demux_212_buf_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo_zero (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (in),
        .push    (push_zero),
        .pop_req (zero_ready),
        .rd_data (zero),
        .valid   (zero_valid),
        .full    (zero_full),
        .cnt     (zero_cnt)
    );

    demux_212_buf_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo_one (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (in),
        .push    (push_one),
        .pop_req (one_ready),
        .rd_data (one),
        .valid   (one_valid),
        .full    (one_full),
        .cnt     (one_cnt)
    );

endmodule

// File: tb/tb_demux_212_buf.sv
// Scoreboard bench for demux_212_buf: a queue-based model predicts accepted words,
// occupancy and readiness; a negedge monitor compares every presented output.

module tb_demux_212_buf;

    localparam int W     = 12;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in;
    logic          in_valid;
    logic          sel;
    logic          in_ready;
    logic [W-1:0]  zero;
    logic          zero_valid;
    logic          zero_ready;
    logic [CW-1:0] zero_cnt;
    logic [W-1:0]  one;
    logic          one_valid;
    logic          one_ready;
    logic [CW-1:0] one_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] qz[$];
    logic [W-1:0] qo[$];
    int  ecz;
    int  eco;
    logic stall;
    logic m_acc;
    int   m_pz, m_po, m_rz, m_ro;

    demux_212_buf #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .sel        (sel),
        .in_ready   (in_ready),
        .zero       (zero),
        .zero_valid (zero_valid),
        .zero_ready (zero_ready),
        .zero_cnt   (zero_cnt),
        .one        (one),
        .one_valid  (one_valid),
        .one_ready  (one_ready),
        .one_cnt    (one_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: each destination is a bounded queue of DEPTH words.
    assign m_acc = in_valid && ((sel ? eco : ecz) < DEPTH);
    assign m_pz  = (m_acc && !sel) ? 1 : 0;
    assign m_po  = (m_acc &&  sel) ? 1 : 0;
    assign m_rz  = (zero_ready && ecz > 0) ? 1 : 0;
    assign m_ro  = (one_ready  && eco > 0) ? 1 : 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecz   <= 0;
            eco   <= 0;
            stall <= 1'b0;
            qz.delete();
            qo.delete();
        end else begin
            if (m_pz == 1) qz.push_back(in);
            if (m_po == 1) qo.push_back(in);
            ecz   <= ecz + m_pz - m_rz;
            eco   <= eco + m_po - m_ro;
            stall <= in_valid && !m_acc;
        end
    end

    // Monitor: compare head words, occupancy and readiness; retire a word on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("zero_cnt", int'(zero_cnt), ecz);
            check("one_cnt", int'(one_cnt), eco);
            check("zero_valid", int'(zero_valid), (ecz != 0) ? 1 : 0);
            check("one_valid", int'(one_valid), (eco != 0) ? 1 : 0);
            check("in_ready", int'(in_ready), (((sel ? eco : ecz) < DEPTH) ? 1 : 0));
            if (zero_valid) begin
                if (qz.size() == 0) check("zero_unexpected", int'(zero), -1);
                else begin
                    check("zero_data", int'(zero), int'(qz[0]));
                    if (zero_ready) void'(qz.pop_front());
                end
            end else begin
                check("zero_idle", int'(zero), 0);
            end
            if (one_valid) begin
                if (qo.size() == 0) check("one_unexpected", int'(one), -1);
                else begin
                    check("one_data", int'(one), int'(qo[0]));
                    if (one_ready) void'(qo.pop_front());
                end
            end else begin
                check("one_idle", int'(one), 0);
            end
        end
    end

    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic zr, input logic orr);
        in_valid   = v;
        sel        = s;
        in         = d;
        zero_ready = zr;
        one_ready  = orr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        sel = 1'b0;
        #1;
        check({tag, "_zero_valid"}, int'(zero_valid), 0);
        check({tag, "_one_valid"}, int'(one_valid), 0);
        check({tag, "_zero"}, int'(zero), 0);
        check({tag, "_one"}, int'(one), 0);
        check({tag, "_zero_cnt"}, int'(zero_cnt), 0);
        check({tag, "_one_cnt"}, int'(one_cnt), 0);
        check({tag, "_in_ready_sel0"}, int'(in_ready), 1);
        sel = 1'b1;
        #1;
        check({tag, "_in_ready_sel1"}, int'(in_ready), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in         = '0;
        in_valid   = 1'b0;
        sel        = 1'b0;
        zero_ready = 1'b0;
        one_ready  = 1'b0;
        #13;
        reset_checks("por");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One word to each destination with both consumers stalled.
        step(1'b1, 1'b0, 12'h123, 1'b0, 1'b0);
        step(1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("two_dest_zero", int'(zero), 'h123);
        check("two_dest_one", int'(one), 'hABC);
        drain();

        // Fill ZERO, push into ONE while ZERO is full, then backpressure on the third word.
        step(1'b1, 1'b0, 12'h001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h002, 1'b0, 1'b0);
        sel = 1'b0;
        #1;
        check("zero_full_in_ready", int'(in_ready), 0);
        step(1'b1, 1'b1, 12'h7FF, 1'b0, 1'b0);
        check("zero_kept_cnt", int'(zero_cnt), 2);
        check("one_got_7ff", int'(one), 'h7FF);
        step(1'b1, 1'b0, 12'h003, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h003, 1'b1, 1'b0);
        check("pop_not_accept_cnt", int'(zero_cnt), 1);
        step(1'b1, 1'b0, 12'h003, 1'b0, 1'b0);
        check("held_word_accepted_cnt", int'(zero_cnt), 2);
        drain();

        // Streaming to ONE with its consumer always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 12'(12'h010 + i), 1'b0, 1'b1);
            check("stream_cnt_le1", (int'(one_cnt) <= 1) ? 1 : 0, 1);
        end
        drain();

        // Fill both, then an asynchronous reset pulse between edges.
        step(1'b1, 1'b0, 12'h111, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h222, 1'b0, 1'b0);
        step(1'b1, 1'b1, 12'h333, 1'b0, 1'b0);
        step(1'b1, 1'b1, 12'h444, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        reset_checks("mid");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 12'h5A5, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("post_reset_zero", int'(zero), 'h5A5);
        check("post_reset_one_valid", int'(one_valid), 0);
        drain();

        // Random traffic; a stalled word is held stable until accepted.
        for (int i = 0; i < 400; i++) begin
            if (stall) step(1'b1, sel, in, 1'($urandom), 1'($urandom));
            else step(1'($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
        end
        in_valid = 1'b0;
        drain();
        check("final_zero_cnt", int'(zero_cnt), 0);
        check("final_one_cnt", int'(one_cnt), 0);
        check("scoreboard_drained", qz.size() + qo.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_212_buf.md
# demux_212_buf

Buffered 1:2 demultiplexer that routes a W-bit word to one of two destinations, ZERO or ONE, under control of SEL. It is the inverse of the 12-bit 2:1 select used on the PC/address path: where that block merges two sources into one, this block steers one producer to two consumers. Each destination has its own DEPTH-entry FIFO with a VALID/READY handshake, so a stalled consumer never drops or reorders words bound for the other.

## Interface
- W, 12, data width in bits
- DEPTH, 2, entries per destination FIFO; power of two, minimum 2
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- IN  in  W  input word
- IN_VALID  in  1  producer has a word on IN
- SEL  in  1  destination of the current word: 0 = ZERO, 1 = ONE; sampled with IN
- IN_READY  out  1  selected FIFO can accept a word this cycle
- ZERO  out  W  head word of the ZERO FIFO
- ZERO_VALID  out  1  ZERO FIFO non-empty
- ZERO_READY  in  1  ZERO consumer takes the head word
- ZERO_CNT  out  $clog2(DEPTH)+1  ZERO FIFO occupancy
- ONE  out  W  head word of the ONE FIFO
- ONE_VALID  out  1  ONE FIFO non-empty
- ONE_READY  in  1  ONE consumer takes the head word
- ONE_CNT  out  $clog2(DEPTH)+1  ONE FIFO occupancy

## Operation
- Push: IN_VALID & IN_READY at a CLK edge writes IN into the FIFO chosen by SEL and increments its count. Nothing is written to the other FIFO.
- IN_READY = ~full(SEL ? ONE : ZERO). This path is combinational from SEL and the registered counts only. There is no dependency on the *_READY inputs, so a full FIFO rejects a push even in a cycle where it is being popped.
- Pop: x_VALID & x_READY at a CLK edge advances the read pointer of FIFO x and decrements its count.
- x_VALID = (x_CNT != 0). x_READY asserted while x_VALID is low has no effect.
- Data outputs: x = mem[rd_ptr] when non-empty, and 0 when empty. No X is ever driven.
- Push and pop on the same FIFO in the same cycle (possible only when it is not full): count is unchanged, and both pointers advance.
- Push to one FIFO while popping the other: the two FIFOs update independently.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full is (CNT == DEPTH). Counts never exceed DEPTH and never underflow.
- Each destination is strictly FIFO. Words to the same destination leave in acceptance order. There is no ordering guarantee between ZERO and ONE.
- A producer holding IN_VALID while IN_READY is low must keep IN and SEL stable until the push completes. This block does not check that rule.

## Timing
- Reset (RST_N low, asynchronous): all pointers and counts go to 0. ZERO_VALID, ONE_VALID, ZERO, ONE, ZERO_CNT and ONE_CNT go to 0. IN_READY goes to 1 for either SEL value.
- Reset asserted mid-operation flushes both FIFOs immediately, without waiting for an edge. Buffered words are lost.
- Operation resumes on the first CLK edge after RST_N deasserts.
- Latency: a word accepted at edge n is visible on x with x_VALID high after edge n. The earliest pop is at edge n+1. There is no same-cycle bypass.
- Throughput: one push per cycle, plus one pop per destination per cycle. With x_READY held high, a single destination sustains 1 word per cycle.
- All outputs except IN_READY are registered or decoded from registers. IN_READY is combinational from SEL.

## Test plan
- Reset then idle, with RST_N pulsed low mid-cycle: all outputs 0, IN_READY = 1 for SEL = 0 and for SEL = 1, both counts 0.
- Push 0x123 (SEL = 0) and 0xABC (SEL = 1) on consecutive edges, with both READY inputs low: ZERO = 0x123, ONE = 0xABC, both VALIDs high, both counts 1.
- Push 0x001, 0x002 and 0x003 to ZERO with ZERO_READY low: IN_READY drops after the 2nd push, and the 3rd word is held. Then raise ZERO_READY for 1 cycle: 0x001 pops, 0x003 is accepted on the next edge, and ZERO sequence 0x002, 0x003 follows.
- While ZERO is full (count 2), present SEL = 1 with 0x7FF: IN_READY = 1, the word is accepted into ONE, and ZERO is unaffected.
- Stream 8 words 0x010..0x017 to ONE with ONE_READY held high: one word per cycle, exact order on ONE, ONE_CNT stays ≤ 1, and pointers wrap without loss.
- Fill both FIFOs, assert RST_N low for 3 ns between edges: both VALIDs and counts go to 0 immediately, and the next push after deassertion is the only word delivered.
